// File: rtl/ethernet_system_pio_pkg.sv
// ethernet_system_pio_pkg
//   Shared definitions for the EthernetSystem Avalon PIO blocks: the 2-bit
//   register map, edge-type selector codes and the edge-event helper used by
//   the button input PIO.
//   No ports (package).
package ethernet_system_pio_pkg;

    // Avalon word addresses of the PIO register map
    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_DIR     = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    // Which transitions of the debounced level set a capture bit
    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    // Per-bit edge events from the current and previous debounced levels.
    // Kept 32 bits wide so every PIO width can share it.
    function automatic logic [31:0] edge_events(input int          edge_type,
                                                input logic [31:0] level,
                                                input logic [31:0] prev);
        logic [31:0] rise;
        logic [31:0] fall;
        rise = level & ~prev;
        fall = ~level & prev;
        case (edge_type)
            EDGE_RISING:  edge_events = rise;
            EDGE_FALLING: edge_events = fall;
            default:      edge_events = rise | fall;
        endcase
    endfunction

endpackage

// File: rtl/pio_debounce_bit.sv
// pio_debounce_bit
//   One input bit of the button PIO: a two-flop synchroniser followed by a
//   debounce counter. The stable level only follows the synchronised input
//   once it has differed from it for DEBOUNCE_CYCLES consecutive clocks;
//   shorter excursions restart the count and are never seen.
//   DEBOUNCE_CYCLES = 0 bypasses the counter (stable follows sync each clock).
// Ports
//   clk      in  system clock
//   reset_n  in  asynchronous active-low reset
//   raw      in  asynchronous button input
//   stable   out debounced level
module pio_debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic stable
);

    logic sync_meta;
    logic sync_out;

    // Plain two-stage synchroniser, nothing between the stages.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= 1'b0;
            sync_out  <= 1'b0;
        end else begin
            sync_meta <= raw;
            sync_out  <= sync_meta;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    stable <= 1'b0;
                end else begin
                    stable <= sync_out;
                end
            end
        end else begin : g_count
            localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [CNT_W-1:0] cnt;

            // cnt is cleared on reaching CNT_LAST, so it can never wrap.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt    <= '0;
                    stable <= 1'b0;
                end else if (sync_out == stable) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    stable <= sync_out;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/ethernet_system_buttons_pio.sv
// ethernet_system_buttons_pio
//   Avalon-MM slave input PIO for the push-buttons. Each bit is synchronised
//   and debounced, edges of the debounced level are latched into an
//   edge-capture register, and a level IRQ is raised from the masked
//   capture bits.
// Ports
//   clk         in  system clock
//   reset_n     in  asynchronous active-low reset
//   address     in  Avalon word address (0 DATA, 1 DIR, 2 MASK, 3 EDGE)
//   chipselect  in  Avalon select
//   write_n     in  Avalon write strobe, active-low
//   writedata   in  Avalon write data
//   readdata    out Avalon read data, combinational from registers
//   in_port     in  raw asynchronous button inputs
//   irq         out level interrupt, active-high
module ethernet_system_buttons_pio
    import ethernet_system_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] events;
    logic [WIDTH-1:0] clear_bits;
    logic             wr;
    logic             unused_wd;

    // Bus handshake: zero-wait Avalon slave. A write takes effect on the
    // clock edge where chipselect=1 and write_n=0; a read needs no strobe
    // and readdata reflects the addressed register in the same cycle.
    assign wr = chipselect & ~write_n;

    // Upper writedata bits beyond WIDTH are deliberately ignored.
    assign unused_wd = ^writedata;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            pio_debounce_bit #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk    (clk),
                .reset_n(reset_n),
                .raw    (in_port[i]),
                .stable (stable[i])
            );
        end
    endgenerate

    always_comb begin
        events     = WIDTH'(edge_events(EDGE_TYPE, 32'(stable), 32'(prev)));
        clear_bits = '0;
        if (wr && (address == ADDR_EDGECAP)) begin
            clear_bits = writedata[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev         <= '0;
            irq_mask     <= '0;
            edge_capture <= '0;
        end else begin
            prev <= stable;
            if (wr && (address == ADDR_IRQMASK)) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
            // New events are OR-ed after the clear so a same-cycle set wins.
            edge_capture <= (edge_capture & ~clear_bits) | events;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata = 32'(stable);
            ADDR_DIR:     readdata = '0;
            ADDR_IRQMASK: readdata = 32'(irq_mask);
            ADDR_EDGECAP: readdata = 32'(edge_capture);
            default:      readdata = '0;
        endcase
    end

    assign irq = |(edge_capture & irq_mask);

endmodule
